// File: rtl/result_collector.sv
// Result collector: captures (accR, accI) on each rising edge of flag, tags it with row/col, buffers it in a FIFO.
// Latency: an entry pushed in cycle N into an empty FIFO is presented on out_* from cycle N+1 (first-word fall-through).
// Backpressure: out_* held while out_valid & !out_ready; a capture arriving on a full FIFO without a pop is dropped (sticky overflow).
module result_collector #(
  parameter int ANCHO_PALABRA = 32,
  parameter int DIM           = 32,
  parameter int DEPTH         = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           flag,
  input  logic [ANCHO_PALABRA-1:0]       accR,
  input  logic [ANCHO_PALABRA-1:0]       accI,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ANCHO_PALABRA-1:0]       out_real,
  output logic [ANCHO_PALABRA-1:0]       out_imag,
  output logic [$clog2(DIM)-1:0]         out_row,
  output logic [$clog2(DIM)-1:0]         out_col,
  output logic                           out_last,
  output logic [$clog2(DIM*DIM):0]       captured,
  output logic                           overflow,
  output logic                           done
);

  localparam int W     = ANCHO_PALABRA;
  localparam int RW    = $clog2(DIM);
  localparam int TOTAL = DIM * DIM;
  localparam int CW    = $clog2(TOTAL) + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int OW    = PW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  typedef struct packed {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic          last;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [1:0]    state;
  logic          flag_d;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] count;
  logic [CW-1:0] captured_q;
  logic          overflow_q;
  logic          done_q;

  logic          edge_det;
  logic          cap_edge;
  logic          full;
  logic          pop;
  logic          push;
  logic          arm;
  logic [31:0]   cap32;
  entry_t        new_entry;
  entry_t        head;

  // Edge detect, FIFO handshake decisions and the tag for the current capture index
  always_comb begin
    edge_det  = flag & ~flag_d;
    cap_edge  = edge_det && (state == S_COLLECT);
    full      = (count == OW'(DEPTH));
    pop       = (count != '0) && out_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle
    push      = cap_edge && (!full || pop);
    arm       = start && ((state == S_IDLE) || (state == S_DONE));
    cap32     = 32'(captured_q);
    new_entry      = '0;
    new_entry.re   = accR;
    new_entry.im   = accI;
    new_entry.row  = RW'(cap32 / 32'(DIM));
    new_entry.col  = RW'(cap32 % 32'(DIM));
    new_entry.last = (cap32 == 32'(TOTAL - 1));
    head      = mem[rd_ptr];
  end

  // Output view of the FIFO head; data reads as zero whenever nothing is presented
  always_comb begin
    out_valid = (count != '0);
    out_real  = '0;
    out_imag  = '0;
    out_row   = '0;
    out_col   = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_real = head.re;
      out_imag = head.im;
      out_row  = head.row;
      out_col  = head.col;
      out_last = head.last;
    end
    captured = captured_q;
    overflow = overflow_q;
    done     = done_q;
  end

  // FIFO storage; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Flag history register, updated every cycle regardless of state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_d <= 1'b0;
    end else begin
      flag_d <= flag;
    end
  end

  // FIFO pointers and occupancy; arming a run empties the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (arm) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + OW'(1);
      else if (pop && !push) count <= count - OW'(1);
    end
  end

  // Run control: capture counting, sticky overflow and the IDLE/COLLECT/FLUSH/DONE sequence
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      captured_q <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_COLLECT;
            captured_q <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (cap_edge) begin
            // Dropped captures still advance the index so later tags stay aligned
            captured_q <= captured_q + CW'(1);
            if (!push) overflow_q <= 1'b1;
            if (captured_q == CW'(TOTAL - 1)) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (count == '0) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector with DIM=4, DEPTH=4.
// Stimulus pushes hand-computed expected entries; a monitor pops and compares on each output handshake.
// Direct checks cover reset, counters, overflow, done and asynchronous reset.
module tb_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flag = 1'b0;
  logic [31:0] accR = '0;
  logic [31:0] accI = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_real;
  logic [31:0] out_imag;
  logic [1:0]  out_row;
  logic [1:0]  out_col;
  logic        out_last;
  logic [4:0]  captured;
  logic        overflow;
  logic        done;

  int n_chk = 0;
  int n_fail = 0;
  logic [68:0] sb[$];

  result_collector #(.ANCHO_PALABRA(32), .DIM(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .flag(flag), .accR(accR), .accI(accI),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .captured(captured), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [68:0] mk(input int re, input int im, input int idx);
    logic [1:0] r;
    logic [1:0] c;
    r = 2'(idx / 4);
    c = 2'(idx % 4);
    return {32'(re), 32'(im), r, c, (idx == 15)};
  endfunction

  // Monitor: every accepted output must match the oldest expected entry
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {59'd0, out_real, out_imag, out_row, out_col, out_last}, 128'd0);
      end else begin
        check("entry", {59'd0, out_real, out_imag, out_row, out_col, out_last}, {59'd0, sb.pop_front()});
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse(input int re, input int im);
    @(posedge clk); #1 flag = 1'b1; accR = 32'(re); accI = 32'(im);
    @(posedge clk); #1 flag = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    @(posedge clk); #1;
    check("drain_remaining", 128'(sb.size()), 128'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    // 1: reset state and no capture before start
    #12;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_data", {out_real, out_imag, 4'(out_row), 4'(out_col), 4'(out_last)}, 128'd0);
    check("rst_captured", 128'(captured), 128'd0);
    check("rst_flags", {overflow, done}, 128'd0);
    @(posedge clk); #1 rst = 1'b1; out_ready = 1'b1;
    pulse(5, 6);
    pulse(7, 8);
    check("idle_captured", 128'(captured), 128'd0);
    check("idle_out_valid", 128'(out_valid), 128'd0);

    // 2: full run, sink always ready
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      sb.push_back(mk(i, -i, i));
      pulse(i, -i);
    end
    for (int k = 0; k < 200 && done !== 1'b1; k++) begin @(posedge clk); #1; end
    check("run_done", 128'(done), 128'd1);
    check("run_overflow", 128'(overflow), 128'd0);
    check("run_captured", 128'(captured), 128'd16);
    check("run_queue", 128'(sb.size()), 128'd0);
    check("done_out_valid", 128'(out_valid), 128'd0);

    // 4: held-high flag yields one capture
    pulse_start();
    sb.push_back(mk(100, 200, 0));
    @(posedge clk); #1 flag = 1'b1; accR = 32'd100; accI = 32'd200;
    repeat (10) @(posedge clk);
    #1 flag = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("held_captured", 128'(captured), 128'd1);
    wait_drain();

    // 5: full FIFO with a capture coinciding with a pop
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(mk(10 + i, 20 + i, i));
      pulse(10 + i, 20 + i);
    end
    check("full_captured", 128'(captured), 128'd5);
    check("full_valid", 128'(out_valid), 128'd1);
    sb.push_back(mk(15, 25, 5));
    @(posedge clk); #1 flag = 1'b1; accR = 32'd15; accI = 32'd25; out_ready = 1'b1;
    @(posedge clk); #1 flag = 1'b0;
    check("fullpop_overflow", 128'(overflow), 128'd0);
    check("fullpop_captured", 128'(captured), 128'd6);
    wait_drain();

    // 6: asynchronous reset mid-run, then re-arm
    out_ready = 1'b0;
    pulse(50, 60);
    check("pre_rst_captured", 128'(captured), 128'd7);
    check("pre_rst_valid", 128'(out_valid), 128'd1);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check("async_rst_valid", 128'(out_valid), 128'd0);
    check("async_rst_data", {out_real, out_imag, 4'(out_row), 4'(out_col), 4'(out_last)}, 128'd0);
    check("async_rst_cnt", {captured, overflow, done}, 128'd0);
    @(posedge clk); #1 rst = 1'b1; out_ready = 1'b1;
    pulse_start();
    sb.push_back(mk(77, 88, 0));
    pulse(77, 88);
    check("rearm_captured", 128'(captured), 128'd1);
    wait_drain();

    // 3: overflow with sink stalled, tags of kept entries intact
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) sb.push_back(mk(1000 + i, -1000 - i, i));
      pulse(1000 + i, -1000 - i);
      check("ovf_sticky", 128'(overflow), 128'(i >= 4));
    end
    check("ovf_captured", 128'(captured), 128'd6);
    check("ovf_head_stable", 128'(out_real), 128'd1000);
    out_ready = 1'b1;
    wait_drain();
    repeat (5) @(posedge clk);
    #1 check("ovf_empty_after", 128'(out_valid), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
